bram_stream_reader: RTL



---
 rtl/bram_stream_reader.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//
// Read-only client of a single-port, read-first BRAM port. On an accepted
// start command it reads `length` consecutive words from `base_addr`
// (addresses wrap modulo RAM_DEPTH) and presents them on a valid/ready stream.
//
// The BRAM has a fixed one-cycle read latency and a free-running douta, so a
// read is only issued when there is guaranteed room for its result in a
// 2-entry skid buffer. This keeps full 1 word/cycle throughput when the
// consumer never stalls, and never loses a read result when it does.
//
// Optional feature (compile-time macro BRAM_STREAM_LAST_EN):
//   defined   -> adds output m_last, high on the beat carrying the final word.
//   undefined -> no m_last port; end of block is signalled by done only.
// -----------------------------------------------------------------------------
module bram_stream_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clka,
   input  logic                  rsta_n,
   // command interface
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   // BRAM port (read-only use)
   output logic                  wea,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dina,
   input  logic [DATA_WIDTH-1:0] douta,
   // output stream
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef BRAM_STREAM_LAST_EN
   ,
   output logic                  m_last
`endif
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Control state
   state_t                state_q,    state_d;
   logic [ADDR_WIDTH-1:0] base_q,     base_d;
   logic [ADDR_WIDTH:0]   len_q,      len_d;
   logic [ADDR_WIDTH:0]   issued_q,   issued_d;
   logic                  inflight_q, inflight_d;

   // Skid buffer: entry 0 is always the head of the stream
   logic [DATA_WIDTH-1:0] buf0_q,  buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q,  buf1_d;
   logic [1:0]            count_q, count_d;

`ifdef BRAM_STREAM_LAST_EN
   logic                  last_inflight_q, last_inflight_d;
   logic                  last0_q, last0_d;
   logic                  last1_q, last1_d;
`endif

   logic       push;
   logic       pop;
   logic [2:0] occ_after;
   logic       issue;
   logic       issue_last;

   // Handshake bookkeeping and the read-issue decision
   always_comb begin
      push       = inflight_q;
      pop        = m_valid & m_ready;
      // Slots already committed for the next cycle: buffered words plus the
      // word arriving from the BRAM, minus the word leaving this cycle.
      occ_after  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue      = (state_q == S_RUN) && (issued_q != len_q) && (occ_after < 3'd2);
      issue_last = issue && ((issued_q + CNT_ONE) == len_q);
   end

   // Next-state logic of the transfer sequencer
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path through the case statement can leave it unassigned (no latches).
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      issued_d   = issued_q;
      inflight_d = issue;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d   = base_addr;
               len_d    = length;
               issued_d = '0;
               state_d  = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (issue) begin
               issued_d = issued_q + CNT_ONE;
               if (issue_last) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!inflight_q && (count_q == 2'd0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Skid buffer update: capture douta only when a read was issued last cycle
   always_comb begin
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      count_d = count_q;
`ifdef BRAM_STREAM_LAST_EN
      last0_d         = last0_q;
      last1_d         = last1_q;
      last_inflight_d = issue_last;
`endif

      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               buf0_d = douta;
`ifdef BRAM_STREAM_LAST_EN
               last0_d = last_inflight_q;
`endif
            end else begin
               buf1_d = douta;
`ifdef BRAM_STREAM_LAST_EN
               last1_d = last_inflight_q;
`endif
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            buf0_d  = buf1_q;
`ifdef BRAM_STREAM_LAST_EN
            last0_d = last1_q;
`endif
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged: the new word joins behind whatever remains.
            if (count_q == 2'd1) begin
               buf0_d = douta;
`ifdef BRAM_STREAM_LAST_EN
               last0_d = last_inflight_q;
`endif
            end else begin
               buf0_d = buf1_q;
               buf1_d = douta;
`ifdef BRAM_STREAM_LAST_EN
               last0_d = last1_q;
               last1_d = last_inflight_q;
`endif
            end
         end
         default: begin
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         // NOTE: the skid buffer is only two registers, so it is reset along
         // with the control state; this also makes m_data read 0 after reset.
         buf0_q     <= '0;
         buf1_q     <= '0;
         count_q    <= 2'd0;
`ifdef BRAM_STREAM_LAST_EN
         last_inflight_q <= 1'b0;
         last0_q         <= 1'b0;
         last1_q         <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // values from before this edge, independent of statement order.
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         count_q    <= count_d;
`ifdef BRAM_STREAM_LAST_EN
         last_inflight_q <= last_inflight_d;
         last0_q         <= last0_d;
         last1_q         <= last1_d;
`endif
      end
   end

   // Output decode: all outputs come from registers, no combinational paths
   // from m_ready or douta.
   always_comb begin
      busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
      done    = (state_q == S_DONE);
      wea     = 1'b0;
      dina    = '0;
      // Next address to read; the narrower add wraps modulo RAM_DEPTH.
      addra   = base_q + issued_q[ADDR_WIDTH-1:0];
      m_valid = (count_q != 2'd0);
      m_data  = buf0_q;
`ifdef BRAM_STREAM_LAST_EN
      m_last  = m_valid & last0_q;
`endif
   end

endmodule
